// File: rtl/corr_frame_sched_if.sv
// -----------------------------------------------------------------------------
// corr_frame_sched_if
// Pipeline-facing bundle between the frame scheduler and the direct-
// correspondence pipeline (Idx2Cloud -> TransMat -> Proj) plus frame memory.
//   master : driven by corr_frame_sched
//            o_rd_en, o_rd_addr     frame memory read request
//            o_valid, o_frame_start,
//            o_frame_end            pixel sideband aligned to read data
//            o_pose                 active pose, 12 entries of POSE_BW bits
//            i_corr_frame_end       (input) pipeline end-of-frame loopback
//   slave  : the pipeline / memory side, mirror image of master
// -----------------------------------------------------------------------------
interface corr_frame_sched_if #(
    parameter int ADDR_BW = 19,
    parameter int POSE_BW = 32
);
    logic                         o_rd_en;
    logic [ADDR_BW-1:0]           o_rd_addr;
    logic                         o_valid;
    logic                         o_frame_start;
    logic                         o_frame_end;
    logic [11:0][POSE_BW-1:0]     o_pose;
    logic                         i_corr_frame_end;

    modport master (
        output o_rd_en, o_rd_addr, o_valid, o_frame_start, o_frame_end, o_pose,
        input  i_corr_frame_end
    );

    modport slave (
        input  o_rd_en, o_rd_addr, o_valid, o_frame_start, o_frame_end, o_pose,
        output i_corr_frame_end
    );
endinterface

// File: rtl/corr_frame_sched.sv
// -----------------------------------------------------------------------------
// corr_frame_sched
// Frame-level scheduler for the direct-correspondence pipeline. Walks one
// RGB-D frame out of frame memory in raster order, produces the valid /
// frame_start / frame_end sideband aligned to the read data, freezes the pose
// for the whole frame (shadow bank written any time, active bank loaded on an
// accepted start), then waits for the pipeline to drain and reports done or
// timeout.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start                 pulse: begin one frame
//   r_hsize, r_vsize        frame geometry, sampled on an accepted start
//   i_pose_we/idx/wdata     shadow pose write port (idx 12..15 ignored)
//   i_hold                  throttle: no read issued while high
//   pipe (master)           memory read request, sideband, pose, loopback
//   o_busy                  FSM not in IDLE
//   o_done                  1-cycle pulse: frame drained
//   o_err                   1-cycle pulse: rejected start or drain timeout
// -----------------------------------------------------------------------------
module corr_frame_sched #(
    parameter int ADDR_BW   = 19,
    parameter int RD_LAT    = 1,
    parameter int PIPE_LAT  = 12,
    parameter int TO_SLACK  = 8,
    parameter int H_SIZE_BW = 10,
    parameter int V_SIZE_BW = 9,
    parameter int POSE_BW   = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [H_SIZE_BW-1:0] r_hsize,
    input  logic [V_SIZE_BW-1:0] r_vsize,
    input  logic                 i_pose_we,
    input  logic [3:0]           i_pose_idx,
    input  logic [POSE_BW-1:0]   i_pose_wdata,
    input  logic                 i_hold,
    corr_frame_sched_if.master   pipe,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    localparam int TO_LIMIT = RD_LAT + PIPE_LAT + TO_SLACK;
    localparam int TMR_BW   = $clog2(TO_LIMIT + 1);
    localparam int CNT_BW   = ADDR_BW + 1;
    localparam logic [CNT_BW-1:0] CNT_ONE = CNT_BW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic issue;
        logic start;
        logic last;
    } sb_t;

    state_t                   state_q, state_d;
    logic [CNT_BW-1:0]        cnt_q, cnt_d;
    logic [CNT_BW-1:0]        total_q, total_d;
    logic [TMR_BW-1:0]        timer_q, timer_d;
    logic [11:0][POSE_BW-1:0] shadow_q, shadow_d;
    logic [11:0][POSE_BW-1:0] active_q, active_d;
    sb_t                      sb_q [RD_LAT];
    sb_t                      sb_d [RD_LAT];

    logic [CNT_BW-1:0]        start_total;
    logic                     rd_en;
    logic                     tag_start;
    logic                     tag_end;
    logic                     done;
    logic                     err;

    // Both operands widened first so the product is formed at full frame size.
    assign start_total = CNT_BW'(r_hsize) * CNT_BW'(r_vsize);

    // NOTE: every variable driven here gets a default before the case, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        total_d   = total_q;
        timer_d   = timer_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        rd_en     = 1'b0;
        tag_start = 1'b0;
        tag_end   = 1'b0;
        done      = 1'b0;
        err       = 1'b0;

        if (i_pose_we && (i_pose_idx < 4'd12)) begin
            shadow_d[i_pose_idx] = i_pose_wdata;
        end

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (start_total == '0) begin
                        err = 1'b1;
                    end else begin
                        total_d  = start_total;
                        cnt_d    = '0;
                        // shadow_q, not shadow_d: a same-cycle write is not
                        // part of this frame's pose.
                        active_d = shadow_q;
                        state_d  = ISSUE;
                    end
                end
            end

            ISSUE: begin
                err = i_start;
                if (!i_hold) begin
                    rd_en     = 1'b1;
                    tag_start = (cnt_q == '0);
                    tag_end   = (cnt_q == total_q - CNT_ONE);
                    if (tag_end) begin
                        cnt_d   = '0;
                        timer_d = '0;
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            DRAIN: begin
                err = i_start;
                if (pipe.i_corr_frame_end) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (timer_q == TMR_BW'(TO_LIMIT)) begin
                    err     = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TMR_BW'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Sideband delay line: stage 0 takes this cycle's issue tags, the last
    // stage lines up with the frame memory read data.
    always_comb begin
        sb_d[0].issue = rd_en;
        sb_d[0].start = tag_start;
        sb_d[0].last  = tag_end;
        for (int i = 1; i < RD_LAT; i++) begin
            sb_d[i] = sb_q[i-1];
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    // NOTE: the pose banks are reset on purpose: the pipeline must see a zero
    // pose after reset, not whatever the registers powered up with.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            total_q  <= '0;
            timer_q  <= '0;
            shadow_q <= '0;
            active_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                sb_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            total_q  <= total_d;
            timer_q  <= timer_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            for (int i = 0; i < RD_LAT; i++) begin
                sb_q[i] <= sb_d[i];
            end
        end
    end

    assign pipe.o_rd_en       = rd_en;
    assign pipe.o_rd_addr     = cnt_q[ADDR_BW-1:0];
    assign pipe.o_valid       = sb_q[RD_LAT-1].issue;
    assign pipe.o_frame_start = sb_q[RD_LAT-1].start;
    assign pipe.o_frame_end   = sb_q[RD_LAT-1].last;
    assign pipe.o_pose        = active_q;

    assign o_busy = (state_q != IDLE);
    assign o_done = done;
    assign o_err  = err;

endmodule

// File: tb/tb_corr_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_corr_frame_sched
// Directed bench for corr_frame_sched with RD_LAT=1, PIPE_LAT=12, TO_SLACK=8.
// Inputs change 1 time unit after a rising edge; outputs are compared 1 unit
// later, well clear of the next edge. The pipeline loopback is driven by hand
// PIPE_LAT cycles after the o_frame_end beat.
// -----------------------------------------------------------------------------
module tb_corr_frame_sched;

    localparam int ADDR_BW   = 19;
    localparam int RD_LAT    = 1;
    localparam int PIPE_LAT  = 12;
    localparam int TO_SLACK  = 8;
    localparam int H_SIZE_BW = 10;
    localparam int V_SIZE_BW = 9;
    localparam int POSE_BW   = 32;

    logic                 clk;
    logic                 rst_n;
    logic                 i_start;
    logic [H_SIZE_BW-1:0] r_hsize;
    logic [V_SIZE_BW-1:0] r_vsize;
    logic                 i_pose_we;
    logic [3:0]           i_pose_idx;
    logic [POSE_BW-1:0]   i_pose_wdata;
    logic                 i_hold;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_err;

    int n_checks = 0;
    int n_errs   = 0;

    corr_frame_sched_if #(.ADDR_BW(ADDR_BW), .POSE_BW(POSE_BW)) pipe_if ();

    corr_frame_sched #(
        .ADDR_BW   (ADDR_BW),
        .RD_LAT    (RD_LAT),
        .PIPE_LAT  (PIPE_LAT),
        .TO_SLACK  (TO_SLACK),
        .H_SIZE_BW (H_SIZE_BW),
        .V_SIZE_BW (V_SIZE_BW),
        .POSE_BW   (POSE_BW)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (i_start),
        .r_hsize      (r_hsize),
        .r_vsize      (r_vsize),
        .i_pose_we    (i_pose_we),
        .i_pose_idx   (i_pose_idx),
        .i_pose_wdata (i_pose_wdata),
        .i_hold       (i_hold),
        .pipe         (pipe_if),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drain phase with loopback: DRAIN cycle 0 is the caller's current cycle.
    task automatic drain_with_loopback(input string tag);
        for (int d = 1; d <= PIPE_LAT; d++) begin
            cyc();
            pipe_if.i_corr_frame_end = (d == PIPE_LAT);
            #1;
            check($sformatf("%s_done_d%0d", tag, d), 64'(o_done), 64'(d == PIPE_LAT));
            check($sformatf("%s_err_d%0d", tag, d), 64'(o_err), 64'd0);
        end
        cyc();
        pipe_if.i_corr_frame_end = 1'b0;
        #1;
        check({tag, "_idle_busy"}, 64'(o_busy), 64'd0);
        check({tag, "_idle_done"}, 64'(o_done), 64'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench exceeded its time budget");
    end

    initial begin
        int  next_addr;
        int  nvalid;
        logic prev_issue;
        logic hold;

        rst_n                    = 1'b0;
        i_start                  = 1'b0;
        r_hsize                  = '0;
        r_vsize                  = '0;
        i_pose_we                = 1'b0;
        i_pose_idx               = '0;
        i_pose_wdata             = '0;
        i_hold                   = 1'b0;
        pipe_if.i_corr_frame_end = 1'b0;

        // ---------------- reset state ----------------
        #12;
        check("rst_rd_en",  64'(pipe_if.o_rd_en), 64'd0);
        check("rst_valid",  64'(pipe_if.o_valid), 64'd0);
        check("rst_busy",   64'(o_busy), 64'd0);
        check("rst_pose5",  64'(pipe_if.o_pose[5]), 64'd0);
        cyc();
        rst_n = 1'b1;

        // Preload shadow idx5 so the first frame has a non-zero old value.
        cyc();
        i_pose_we = 1'b1; i_pose_idx = 4'd5; i_pose_wdata = 32'h0000_AAAA;
        cyc();
        i_pose_we = 1'b0;
        #1;
        check("preload_active_unchanged", 64'(pipe_if.o_pose[5]), 64'd0);

        // ---------------- 4x2 frame, pose write on start cycle ----------------
        cyc();
        i_start = 1'b1; r_hsize = 10'd4; r_vsize = 9'd2;
        i_pose_we = 1'b1; i_pose_idx = 4'd5; i_pose_wdata = 32'h0000_1234;
        #1;
        check("f1_start_err",  64'(o_err), 64'd0);
        check("f1_start_busy", 64'(o_busy), 64'd0);
        for (int k = 0; k < 8; k++) begin
            cyc();
            i_start      = 1'b0;
            r_hsize      = 10'd7;
            i_pose_we    = (k == 4);
            i_pose_wdata = 32'h0000_5678;
            #1;
            check($sformatf("f1_rd_en_%0d", k),  64'(pipe_if.o_rd_en), 64'd1);
            check($sformatf("f1_addr_%0d", k),   64'(pipe_if.o_rd_addr), 64'(k));
            check($sformatf("f1_valid_%0d", k),  64'(pipe_if.o_valid), 64'(k != 0));
            check($sformatf("f1_fstart_%0d", k), 64'(pipe_if.o_frame_start), 64'(k == 1));
            check($sformatf("f1_fend_%0d", k),   64'(pipe_if.o_frame_end), 64'd0);
            check($sformatf("f1_pose5_%0d", k),  64'(pipe_if.o_pose[5]), 64'h0000_AAAA);
        end
        cyc();
        i_pose_we = 1'b0;
        #1;
        check("f1_drain_rd_en",  64'(pipe_if.o_rd_en), 64'd0);
        check("f1_last_valid",   64'(pipe_if.o_valid), 64'd1);
        check("f1_last_fend",    64'(pipe_if.o_frame_end), 64'd1);
        check("f1_last_fstart",  64'(pipe_if.o_frame_start), 64'd0);
        check("f1_drain_busy",   64'(o_busy), 64'd1);
        drain_with_loopback("f1");
        check("f1_pose5_after", 64'(pipe_if.o_pose[5]), 64'h0000_AAAA);

        // ------- 4x2 frame, hold 3 cycles at addr 3, start rejected mid-ISSUE -------
        cyc();
        i_start = 1'b1; r_hsize = 10'd4; r_vsize = 9'd2;
        #1;
        check("f2_start_err", 64'(o_err), 64'd0);
        next_addr  = 0;
        nvalid     = 0;
        prev_issue = 1'b0;
        for (int c = 0; c < 11; c++) begin
            cyc();
            hold    = (c >= 3) && (c < 6);
            i_start = (c == 1);
            i_hold  = hold;
            #1;
            check($sformatf("f2_err_%0d", c),   64'(o_err), 64'(c == 1));
            check($sformatf("f2_rd_en_%0d", c), 64'(pipe_if.o_rd_en), 64'(!hold));
            check($sformatf("f2_valid_%0d", c), 64'(pipe_if.o_valid), 64'(prev_issue));
            if (!hold) begin
                check($sformatf("f2_addr_%0d", c), 64'(pipe_if.o_rd_addr), 64'(next_addr));
                next_addr++;
            end
            if (pipe_if.o_valid) nvalid++;
            prev_issue = !hold;
        end
        check("f2_pose5_new", 64'(pipe_if.o_pose[5]), 64'h0000_5678);
        cyc();
        i_start = 1'b0; i_hold = 1'b0;
        #1;
        if (pipe_if.o_valid) nvalid++;
        check("f2_last_fend",    64'(pipe_if.o_frame_end), 64'd1);
        check("f2_drain_rd_en",  64'(pipe_if.o_rd_en), 64'd0);
        check("f2_valid_beats",  64'(nvalid), 64'd8);
        drain_with_loopback("f2");

        // ---------------- zero-size start rejected ----------------
        cyc();
        i_start = 1'b1; r_hsize = 10'd0; r_vsize = 9'd5;
        #1;
        check("zero_err", 64'(o_err), 64'd1);
        cyc();
        i_start = 1'b0;
        #1;
        check("zero_busy",  64'(o_busy), 64'd0);
        check("zero_err2",  64'(o_err), 64'd0);
        check("zero_rd_en", 64'(pipe_if.o_rd_en), 64'd0);

        // ---------------- drain timeout (2x1 frame, no loopback) ----------------
        cyc();
        i_start = 1'b1; r_hsize = 10'd2; r_vsize = 9'd1;
        cyc();
        i_start = 1'b0;
        cyc();
        #1;
        check("to_end_addr", 64'(pipe_if.o_rd_addr), 64'd1);
        for (int d = 0; d <= RD_LAT + PIPE_LAT + TO_SLACK; d++) begin
            cyc();
            #1;
            check($sformatf("to_err_d%0d", d),  64'(o_err), 64'(d == RD_LAT + PIPE_LAT + TO_SLACK));
            check($sformatf("to_busy_d%0d", d), 64'(o_busy), 64'd1);
        end
        cyc();
        #1;
        check("to_idle_busy", 64'(o_busy), 64'd0);
        check("to_idle_err",  64'(o_err), 64'd0);

        // ---------------- single-pixel frame ----------------
        cyc();
        i_start = 1'b1; r_hsize = 10'd1; r_vsize = 9'd1;
        cyc();
        i_start = 1'b0;
        #1;
        check("px1_rd_en", 64'(pipe_if.o_rd_en), 64'd1);
        check("px1_addr",  64'(pipe_if.o_rd_addr), 64'd0);
        cyc();
        #1;
        check("px1_valid",  64'(pipe_if.o_valid), 64'd1);
        check("px1_fstart", 64'(pipe_if.o_frame_start), 64'd1);
        check("px1_fend",   64'(pipe_if.o_frame_end), 64'd1);
        check("px1_rd_en2", 64'(pipe_if.o_rd_en), 64'd0);
        drain_with_loopback("px1");

        // ---------------- asynchronous reset mid-ISSUE ----------------
        cyc();
        i_start = 1'b1; r_hsize = 10'd4; r_vsize = 9'd2;
        cyc();
        i_start = 1'b0;
        cyc();
        #1;
        check("mr_pre_valid", 64'(pipe_if.o_valid), 64'd1);
        check("mr_pre_addr",  64'(pipe_if.o_rd_addr), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mr_rd_en",  64'(pipe_if.o_rd_en), 64'd0);
        check("mr_addr",   64'(pipe_if.o_rd_addr), 64'd0);
        check("mr_valid",  64'(pipe_if.o_valid), 64'd0);
        check("mr_fstart", 64'(pipe_if.o_frame_start), 64'd0);
        check("mr_busy",   64'(o_busy), 64'd0);
        check("mr_pose5",  64'(pipe_if.o_pose[5]), 64'd0);
        check("mr_err",    64'(o_err), 64'd0);
        cyc();
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
